floppy_track_ctrl: RTL and testbench

- Sequences SD-card sector transfers that fill and flush the single-track floppy buffer (13 × 512 B = 6656 B) behind the Disk II emulation.
- Detects head-track changes and image mounts, writes back a dirty track before loading the new one, and holds the CPU via cpu_wait while a transfer is in flight.
- Sits between apple2_top (track, buffer-write strobe) and the SD channel 0 handshake (sd_lba/sd_rd/sd_wr/sd_ack).

---
 rtl/apple2_disk_pkg.sv | 23 ++
 rtl/sd_sector_hs.sv | 36 +++
 rtl/floppy_track_ctrl.sv | 150 +++++++++++++++
 tb/tb_floppy_track_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/apple2_disk_pkg.sv
// Shared definitions for the Apple II disk emulation: transfer FSM states,
// buffer geometry and the track/sector to SD block address mapping.
package apple2_disk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_XFER,
        RD_REQ,
        RD_XFER
    } disk_state_t;

    localparam int SECTOR_BYTES = 512;
    localparam int TRACK_BYTES  = 6656;

    // Block address of one 512-byte sector of a track image.
    function automatic logic [31:0] lba_of(input logic [31:0] trk,
                                           input logic [31:0] sec,
                                           input int          spt);
        return trk * 32'(spt) + sec;
    endfunction

endpackage

// File: rtl/sd_sector_hs.sv
// One-sector SD request/acknowledge handshake: raises rd or wr on start,
// drops it when ack rises and reports done when ack falls.
module sd_sector_hs (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_write,
    input  logic sd_ack,
    output logic done,
    output logic sd_rd,
    output logic sd_wr
);

    logic old_ack;

    // NOTE: state is written with <= only, so every reader sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_ack <= 1'b0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
        end else begin
            old_ack <= sd_ack;
            if (start) begin
                sd_rd <= !is_write;
                sd_wr <= is_write;
            end else if (sd_ack && !old_ack) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end
        end
    end

    assign done = old_ack && !sd_ack;

endmodule

// File: rtl/floppy_track_ctrl.sv
// Fills and flushes the single-track floppy buffer over SD channel 0.
// Define FDD_WRITEBACK_EN to enable dirty tracking and track writeback.
module floppy_track_ctrl
    import apple2_disk_pkg::*;
#(
    parameter int SECTORS_PER_TRACK = 13,
    parameter int TRACK_W           = 6,
    parameter int LBA_W             = 32
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [TRACK_W-1:0] track,
    input  logic               fd_write,
    input  logic               img_mounted,
    input  logic               img_size_nz,
    input  logic               img_readonly,
    input  logic               sd_ack,
    output logic [LBA_W-1:0]   sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    output logic [3:0]         track_sec,
    output logic               cpu_wait,
    output logic               dirty,
    output logic               busy
);

    localparam logic [3:0] LAST_SEC = 4'(SECTORS_PER_TRACK - 1);

    disk_state_t        state;
    logic               mounted;
    logic               reload_pending;
    logic [TRACK_W-1:0] cur_track;
    logic               hs_start;
    logic               hs_write;
    logic               hs_done;
    logic               need_load;

    assign hs_start  = (state == RD_REQ) || (state == WB_REQ);
    assign busy      = (state != IDLE);
    assign need_load = mounted && ((track != cur_track) || reload_pending);

`ifdef FDD_WRITEBACK_EN
    logic protect;
    assign hs_write = (state == WB_REQ);
`else
    logic unused_ok;
    assign hs_write  = 1'b0;
    assign dirty     = 1'b0;
    assign unused_ok = &{1'b0, fd_write, img_readonly};
`endif

    sd_sector_hs u_hs (
        .clk      (clk_sys),
        .reset    (reset),
        .start    (hs_start),
        .is_write (hs_write),
        .sd_ack   (sd_ack),
        .done     (hs_done),
        .sd_rd    (sd_rd),
        .sd_wr    (sd_wr)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mounted        <= 1'b0;
            reload_pending <= 1'b0;
            cur_track      <= '0;
            track_sec      <= '0;
            sd_lba         <= '0;
            cpu_wait       <= 1'b0;
`ifdef FDD_WRITEBACK_EN
            protect        <= 1'b0;
            dirty          <= 1'b0;
`endif
        end else begin
            // A mount is recorded in any state; the reload itself waits for IDLE.
            if (img_mounted) begin
                mounted        <= img_size_nz;
                reload_pending <= 1'b1;
`ifdef FDD_WRITEBACK_EN
                protect        <= img_readonly;
`endif
            end
`ifdef FDD_WRITEBACK_EN
            if (img_mounted)
                dirty <= 1'b0;
            else if (fd_write && mounted && !protect)
                dirty <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (!img_mounted && need_load) begin
                        track_sec <= '0;
                        cpu_wait  <= 1'b1;
`ifdef FDD_WRITEBACK_EN
                        if (dirty) begin
                            dirty <= 1'b0;
                            state <= WB_REQ;
                        end else begin
                            cur_track <= track;
                            state     <= RD_REQ;
                        end
`else
                        cur_track <= track;
                        state     <= RD_REQ;
`endif
                    end
                end
                RD_REQ: begin
                    sd_lba <= LBA_W'(lba_of(32'(cur_track), 32'(track_sec), SECTORS_PER_TRACK));
                    state  <= RD_XFER;
                end
                RD_XFER: begin
                    if (hs_done) begin
                        if (track_sec == LAST_SEC) begin
                            if (!img_mounted)
                                reload_pending <= 1'b0;
                            cpu_wait <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            track_sec <= track_sec + 4'd1;
                            state     <= RD_REQ;
                        end
                    end
                end
`ifdef FDD_WRITEBACK_EN
                WB_REQ: begin
                    sd_lba <= LBA_W'(lba_of(32'(cur_track), 32'(track_sec), SECTORS_PER_TRACK));
                    state  <= WB_XFER;
                end
                WB_XFER: begin
                    if (hs_done) begin
                        if (track_sec == LAST_SEC) begin
                            cur_track <= track;
                            track_sec <= '0;
                            state     <= RD_REQ;
                        end else begin
                            track_sec <= track_sec + 4'd1;
                            state     <= WB_REQ;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_track_ctrl.sv
// Self-checking bench for floppy_track_ctrl: table-driven track load scenarios
// plus hand-written reset-mid-transfer sequence; follows FDD_WRITEBACK_EN.
module tb_floppy_track_ctrl;

`ifdef FDD_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        fd_write, img_mounted, img_size_nz, img_readonly, sd_ack;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, cpu_wait, dirty, busy;
    logic [3:0]  track_sec;

    int n_checks = 0;
    int n_pass   = 0;

    floppy_track_ctrl dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .track        (track),
        .fd_write     (fd_write),
        .img_mounted  (img_mounted),
        .img_size_nz  (img_size_nz),
        .img_readonly (img_readonly),
        .sd_ack       (sd_ack),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .track_sec    (track_sec),
        .cpu_wait     (cpu_wait),
        .dirty        (dirty),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string      name;
        logic       mount;
        logic       size_nz;
        logic       ro;
        logic       fd_wr;
        logic [5:0] trk;
        logic       exp_dirty;
        int         n_wr;
        int         wr_base;
        int         rd_base;
    } scen_t;

    scen_t scen [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Waits for the next sector request, checks it, and acknowledges it.
    task automatic serve(input bit exp_wr, input int exp_lba, input int exp_sec, input bit final_sec);
        int n = 0;
        while (!(sd_rd || sd_wr) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        check("req_seen", 32'(sd_rd | sd_wr), 1);
        check("req_kind", {30'd0, sd_wr, sd_rd}, exp_wr ? 2 : 1);
        check("lba", sd_lba, exp_lba);
        check("track_sec", 32'(track_sec), exp_sec);
        check("cpu_wait_req", 32'(cpu_wait), 1);
        @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("req_drop", {30'd0, sd_wr, sd_rd}, 0);
        sd_ack = 1'b0;
        @(negedge clk_sys);
        check("cpu_wait_after_ack", 32'(cpu_wait), final_sec ? 0 : 1);
        if (final_sec) check("busy_after_last", 32'(busy), 0);
    endtask

    task automatic run_scen(input scen_t s);
        if (s.fd_wr) begin
            fd_write = 1'b1;
            @(negedge clk_sys);
            fd_write = 1'b0;
            @(negedge clk_sys);
            check({s.name, "_dirty"}, 32'(dirty), 32'(s.exp_dirty));
        end
        track = s.trk;
        if (s.mount) begin
            img_mounted  = 1'b1;
            img_size_nz  = s.size_nz;
            img_readonly = s.ro;
        end
        @(negedge clk_sys);
        img_mounted = 1'b0;
        for (int i = 0; i < s.n_wr; i++) serve(1'b1, s.wr_base + i, i, 1'b0);
        for (int i = 0; i < 13; i++) serve(1'b0, s.rd_base + i, i, i == 12);
        repeat (4) @(negedge clk_sys);
        check({s.name, "_idle"}, {27'd0, sd_wr, sd_rd, busy, cpu_wait, dirty}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        scen[0] = '{"mount_t0",    1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 0,         0,  0};
        scen[1] = '{"t0_to_t5",    1'b0, 1'b0, 1'b0, 1'b0, 6'd5,  1'b0, 0,         0,  65};
        scen[2] = '{"dirty_t6",    1'b0, 1'b0, 1'b0, 1'b1, 6'd6,  WB,   WB ? 13 : 0, 65, 78};
        scen[3] = '{"mount_ro",    1'b1, 1'b1, 1'b1, 1'b0, 6'd6,  1'b0, 0,         0,  78};
        scen[4] = '{"ro_write_t7", 1'b0, 1'b0, 1'b0, 1'b1, 6'd7,  1'b0, 0,         0,  91};
        scen[5] = '{"mount_t63",   1'b1, 1'b1, 1'b0, 1'b0, 6'd63, 1'b0, 0,         0,  819};
        scen[6] = '{"mount_wins",  1'b1, 1'b1, 1'b0, 1'b1, 6'd10, WB,   0,         0,  130};

        reset = 1'b1; track = '0; fd_write = 1'b0; img_mounted = 1'b0;
        img_size_nz = 1'b0; img_readonly = 1'b0; sd_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        check("reset_outputs", {sd_lba[19:0], track_sec, 3'd0, sd_rd, sd_wr, cpu_wait, dirty, busy}, 0);

        track = 6'd3;
        repeat (6) @(negedge clk_sys);
        check("unmounted_idle", {29'd0, busy, sd_rd, cpu_wait}, 0);

        for (int i = 0; i < 5; i++) run_scen(scen[i]);

        // Reset during the fourth sector acknowledge of a read.
        track = 6'd8;
        @(negedge clk_sys);
        for (int i = 0; i < 3; i++) serve(1'b0, 104 + i, i, 1'b0);
        begin
            int n = 0;
            while (!sd_rd && n < 200) begin
                @(negedge clk_sys);
                n++;
            end
        end
        check("rst_seq_lba", sd_lba, 107);
        @(negedge clk_sys);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check("rst_async_drop", {27'd0, sd_rd, sd_wr, cpu_wait, busy, dirty}, 0);
        check("rst_async_regs", {sd_lba[27:0], track_sec}, 0);
        @(negedge clk_sys);
        sd_ack = 1'b0;
        reset  = 1'b0;
        repeat (6) @(negedge clk_sys);
        check("post_reset_unmounted", {29'd0, busy, sd_rd, cpu_wait}, 0);

        for (int i = 5; i < 7; i++) run_scen(scen[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
